// File: rtl/shower_pkg.sv
// shower_pkg: shower code constants, FSM encoding and peak helper shared by shower_tx.
package shower_pkg;
  localparam logic [1:0] SH_NONE    = 2'd0;
  localparam logic [1:0] SH_LOOSE   = 2'd1;
  localparam logic [1:0] SH_NOMINAL = 2'd2;
  localparam logic [1:0] SH_TIGHT   = 2'd3;
  typedef enum logic [1:0] {IDLE, COLLECT, SEND, HOLD} state_t;
  function automatic logic [1:0] sh_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/shower_tx_cnt.sv
// shower_tx_cnt: saturating event counter with synchronous clear (clear beats increment).
module shower_tx_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/shower_tx.sv
// shower_tx: qualifies, stretches and deadtimes anode shower codes; monitoring counters under SHOWER_TX_COUNTERS_EN.
import shower_pkg::*;
module shower_tx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       shower_int,
  input  logic             enable,
  input  logic [2:0]       window,
  input  logic [2:0]       stretch,
  input  logic [7:0]       holdoff,
  input  logic             cnt_clr,
  output logic [1:0]       shower_out,
  output logic             shower_valid,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_loose,
  output logic [CNT_W-1:0] cnt_nominal,
  output logic [CNT_W-1:0] cnt_tight
);
  state_t     state;
  logic [2:0] w_sh, s_sh, wcnt, scnt, w_in, s_in;
  logic [7:0] h_sh, hcnt;
  logic [1:0] peak, pk_nxt;
  logic       first, acc, end_op, can_acc;
  assign w_in    = (window == 3'd0) ? 3'd1 : window;
  assign s_in    = (stretch == 3'd0) ? 3'd1 : stretch;
  assign acc     = enable && (shower_int != SH_NONE);
  assign pk_nxt  = sh_max(peak, shower_int);
  // The edge that would return to IDLE doubles as an IDLE edge, so a new shower can be taken there.
  assign end_op  = (state == SEND && scnt == s_sh && h_sh == 8'd0) || (state == HOLD && hcnt == h_sh);
  assign can_acc = (state == IDLE) || end_op;
  assign busy    = (state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      w_sh         <= '0;
      s_sh         <= '0;
      h_sh         <= '0;
      wcnt         <= '0;
      scnt         <= '0;
      hcnt         <= '0;
      peak         <= SH_NONE;
      first        <= 1'b0;
      shower_out   <= SH_NONE;
      shower_valid <= 1'b0;
    end else begin
      first <= 1'b0;
      if (can_acc && acc) begin
        w_sh <= w_in;
        s_sh <= s_in;
        h_sh <= holdoff;
        peak <= shower_int;
        wcnt <= 3'd1;
        scnt <= 3'd1;
        state        <= (w_in == 3'd1) ? SEND : COLLECT;
        first        <= (w_in == 3'd1);
        shower_out   <= (w_in == 3'd1) ? shower_int : SH_NONE;
        shower_valid <= (w_in == 3'd1);
      end else if (can_acc) begin
        state        <= IDLE;
        shower_out   <= SH_NONE;
        shower_valid <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            peak <= pk_nxt;
            wcnt <= wcnt + 3'd1;
            if (wcnt + 3'd1 == w_sh) begin
              state        <= SEND;
              scnt         <= 3'd1;
              first        <= 1'b1;
              shower_out   <= pk_nxt;
              shower_valid <= 1'b1;
            end
          end
          SEND: begin
            scnt <= scnt + 3'd1;
            if (scnt == s_sh) begin
              state        <= HOLD;
              hcnt         <= 8'd1;
              shower_out   <= SH_NONE;
              shower_valid <= 1'b0;
            end
          end
          default: hcnt <= hcnt + 8'd1;
        endcase
      end
    end
  end
`ifdef SHOWER_TX_COUNTERS_EN
  shower_tx_cnt #(.W(CNT_W)) u_loose (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(first && shower_out == SH_LOOSE), .cnt(cnt_loose)
  );
  shower_tx_cnt #(.W(CNT_W)) u_nominal (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(first && shower_out == SH_NOMINAL), .cnt(cnt_nominal)
  );
  shower_tx_cnt #(.W(CNT_W)) u_tight (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(first && shower_out == SH_TIGHT), .cnt(cnt_tight)
  );
`else
  logic unused_cnt;
  assign unused_cnt  = ^{cnt_clr, first};
  assign cnt_loose   = '0;
  assign cnt_nominal = '0;
  assign cnt_tight   = '0;
`endif
endmodule

// File: tb/tb_shower_tx.sv
// tb_shower_tx: scoreboard bench for shower_tx; counter expectations follow SHOWER_TX_COUNTERS_EN.
module tb_shower_tx;
  localparam int CNT_W = 16;
  localparam int CMAX = 65535;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, cnt_clr = 1'b0;
  logic [1:0] shower_int = 2'd0;
  logic [2:0] window = 3'd0, stretch = 3'd0;
  logic [7:0] holdoff = 8'd0;
  logic [1:0] shower_out;
  logic shower_valid, busy;
  logic [CNT_W-1:0] cnt_loose, cnt_nominal, cnt_tight;
  int total = 0, bad = 0;
  int ec [4];
  logic [3:0] q [$];
  logic [3:0] e;

  shower_tx #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .shower_int(shower_int), .enable(enable),
    .window(window), .stretch(stretch), .holdoff(holdoff), .cnt_clr(cnt_clr),
    .shower_out(shower_out), .shower_valid(shower_valid), .busy(busy),
    .cnt_loose(cnt_loose), .cnt_nominal(cnt_nominal), .cnt_tight(cnt_tight)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cexp(input int n);
`ifdef SHOWER_TX_COUNTERS_EN
    return n[CNT_W-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump(input int lvl);
    ec[lvl] = (ec[lvl] == CMAX) ? CMAX : ec[lvl] + 1;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) ec[i] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({shower_valid, shower_out, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0000", {shower_valid, shower_out, busy});
    end
    total++;
    if ({cnt_loose, cnt_nominal, cnt_tight} !== '0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cnt_loose, cnt_nominal, cnt_tight);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ec[i] = 0;
  endtask

  task automatic test_single_loose();
    clear_counters();
    window = 3'd3; stretch = 3'd2; holdoff = 8'd4;
    for (int k = 0; k < 12; k++) begin
      shower_int = (k == 0) ? 2'd1 : 2'd0;
      q.push_back({(k == 2 || k == 3), (k == 2 || k == 3) ? 2'd1 : 2'd0, (k <= 7)});
      if (k == 0) bump(1);
      tick();
      e = q.pop_front();
      total++;
      if ({shower_valid, shower_out, busy} !== e) begin
        bad++;
        $display("FAIL loose_trace k=%0d got=%b exp=%b", k, {shower_valid, shower_out, busy}, e);
      end
    end
    total++;
    if (cnt_loose !== cexp(ec[1])) begin
      bad++;
      $display("FAIL loose_count got=%0d exp=%0d", cnt_loose, cexp(ec[1]));
    end
  endtask

  task automatic test_peak();
    logic [1:0] smp [4];
    smp[0] = 2'd1; smp[1] = 2'd3; smp[2] = 2'd2; smp[3] = 2'd0;
    clear_counters();
    window = 3'd4; stretch = 3'd1; holdoff = 8'd0;
    for (int k = 0; k < 7; k++) begin
      shower_int = (k < 4) ? smp[k] : 2'd0;
      q.push_back({(k == 3), (k == 3) ? 2'd3 : 2'd0, (k <= 3)});
      if (k == 0) bump(3);
      tick();
      e = q.pop_front();
      total++;
      if ({shower_valid, shower_out, busy} !== e) begin
        bad++;
        $display("FAIL peak_trace k=%0d got=%b exp=%b", k, {shower_valid, shower_out, busy}, e);
      end
    end
    total++;
    if ({cnt_loose, cnt_nominal, cnt_tight} !== {cexp(ec[1]), cexp(ec[2]), cexp(ec[3])}) begin
      bad++;
      $display("FAIL peak_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", cnt_loose, cnt_nominal, cnt_tight,
               cexp(ec[1]), cexp(ec[2]), cexp(ec[3]));
    end
  endtask

  task automatic test_deadtime();
    clear_counters();
    window = 3'd1; stretch = 3'd1; holdoff = 8'd5;
    for (int k = 0; k < 26; k++) begin
      shower_int = (k < 20) ? 2'd2 : 2'd0;
      q.push_back({(k < 20 && k % 6 == 0), (k < 20 && k % 6 == 0) ? 2'd2 : 2'd0, (k <= 23)});
      if (k < 20 && k % 6 == 0) bump(2);
      tick();
      e = q.pop_front();
      total++;
      if ({shower_valid, shower_out, busy} !== e) begin
        bad++;
        $display("FAIL deadtime_trace k=%0d got=%b exp=%b", k, {shower_valid, shower_out, busy}, e);
      end
    end
    total++;
    if (cnt_nominal !== cexp(ec[2])) begin
      bad++;
      $display("FAIL deadtime_count got=%0d exp=%0d", cnt_nominal, cexp(ec[2]));
    end
  endtask

  task automatic test_zero_settings();
    clear_counters();
    window = 3'd0; stretch = 3'd0; holdoff = 8'd0;
    shower_int = 2'd3;
    for (int k = 0; k < 65540; k++) begin
      q.push_back({1'b1, 2'd3, 1'b1});
      tick();
      if (k > 0) bump(3);
      e = q.pop_front();
      if (k < 20 || k == 65539) begin
        total++;
        if ({shower_valid, shower_out, busy} !== e) begin
          bad++;
          $display("FAIL zero_trace k=%0d got=%b exp=%b", k, {shower_valid, shower_out, busy}, e);
        end
      end
      if (k == 100) begin
        total++;
        if (cnt_tight !== cexp(ec[3])) begin
          bad++;
          $display("FAIL zero_count_mid got=%0d exp=%0d", cnt_tight, cexp(ec[3]));
        end
      end
    end
    total++;
    if (cnt_tight !== cexp(CMAX)) begin
      bad++;
      $display("FAIL zero_saturate got=%0d exp=%0d", cnt_tight, cexp(CMAX));
    end
    shower_int = 2'd0;
    q.push_back(4'b0);
    tick();
    e = q.pop_front();
    total++;
    if ({shower_valid, shower_out, busy} !== e) begin
      bad++;
      $display("FAIL zero_stop got=%b exp=%b", {shower_valid, shower_out, busy}, e);
    end
  endtask

  task automatic test_reset_mid_send();
    clear_counters();
    window = 3'd1; stretch = 3'd4; holdoff = 8'd3;
    for (int k = 0; k < 13; k++) begin
      rst = (k == 2);
      shower_int = (k == 0) ? 2'd1 : (k == 3) ? 2'd2 : 2'd0;
      if (k < 2) q.push_back({1'b1, 2'd1, 1'b1});
      else if (k == 2) q.push_back(4'b0);
      else q.push_back({(k <= 6), (k <= 6) ? 2'd2 : 2'd0, (k <= 9)});
      if (k == 2) for (int i = 0; i < 4; i++) ec[i] = 0;
      if (k == 3) bump(2);
      tick();
      e = q.pop_front();
      total++;
      if ({shower_valid, shower_out, busy} !== e) begin
        bad++;
        $display("FAIL rst_send_trace k=%0d got=%b exp=%b", k, {shower_valid, shower_out, busy}, e);
      end
      if (k == 2) begin
        total++;
        if ({cnt_loose, cnt_nominal, cnt_tight} !== '0) begin
          bad++;
          $display("FAIL rst_send_counters got=%0d/%0d/%0d exp=0/0/0", cnt_loose, cnt_nominal, cnt_tight);
        end
      end
    end
    rst = 1'b0;
    total++;
    if ({cnt_loose, cnt_nominal} !== {cexp(ec[1]), cexp(ec[2])}) begin
      bad++;
      $display("FAIL rst_send_recount got=%0d/%0d exp=%0d/%0d", cnt_loose, cnt_nominal, cexp(ec[1]), cexp(ec[2]));
    end
  endtask

  task automatic test_cnt_clr_race();
    clear_counters();
    window = 3'd2; stretch = 3'd2; holdoff = 8'd0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        shower_int = (k == 0) ? 2'd2 : 2'd0;
        cnt_clr = (r == 1 && k == 2);
        q.push_back({(k == 1 || k == 2), (k == 1 || k == 2) ? 2'd2 : 2'd0, (k <= 2)});
        if (k == 0) bump(2);
        if (r == 1 && k == 2) for (int i = 0; i < 4; i++) ec[i] = 0;
        tick();
        e = q.pop_front();
        total++;
        if ({shower_valid, shower_out, busy} !== e) begin
          bad++;
          $display("FAIL clr_trace r=%0d k=%0d got=%b exp=%b", r, k, {shower_valid, shower_out, busy}, e);
        end
      end
      cnt_clr = 1'b0;
      total++;
      if (cnt_nominal !== cexp(ec[2])) begin
        bad++;
        $display("FAIL clr_count r=%0d got=%0d exp=%0d", r, cnt_nominal, cexp(ec[2]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_loose();
    test_peak();
    test_deadtime();
    test_zero_settings();
    test_reset_mid_send();
    test_cnt_clr_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
